// File: rtl/fir_pkg.sv
// Shared definitions for the FIR core: micro-op encoding, datapath widths
// and the register-file slot map used by the controller and the datapath.
package fir_pkg;

    localparam int WIDTH = 17;
    localparam int FRAC  = 15;

    typedef enum logic [2:0] {
        NOP     = 3'd0,
        COPY    = 3'd1,
        LOADONE = 3'd2,
        LOADTWO = 3'd3,
        ADD     = 3'd4,
        SUB     = 3'd5,
        MUL     = 3'd6,
        RSVD    = 3'd7
    } opType;

    localparam logic [3:0] R_ACC     = 4'd0;
    localparam logic [3:0] R_SAMPLE0 = 4'd1;
    localparam logic [3:0] R_SAMPLE4 = 4'd5;
    localparam logic [3:0] R_COEF0   = 4'd6;
    localparam logic [3:0] R_COEF3   = 4'd9;
    localparam logic [3:0] R_TMP     = 4'd10;

endpackage

// File: rtl/fir_alu.sv
// Combinational execute stage: turns one micro-op and its two operands into
// the write-back value, a write enable and the signed-overflow flag.
module fir_alu
    import fir_pkg::*;
#(
    parameter int WIDTH = fir_pkg::WIDTH,
    parameter int FRAC  = fir_pkg::FRAC
) (
    input  opType                    op,
    input  logic signed [WIDTH-1:0]  a,
    input  logic signed [WIDTH-1:0]  b,
    input  logic [15:0]              sample_data,
    input  logic [15:0]              fir_coefficient,
    output logic signed [WIDTH-1:0]  result,
    output logic                     overflow,
    output logic                     write_en
);

    localparam int PW = 2 * WIDTH;

    function automatic logic signed [WIDTH-1:0] zext16(input logic [15:0] x);
        return $signed({{(WIDTH-16){1'b0}}, x});
    endfunction

    // Full-precision product shifted down by FRAC; the low WIDTH bits are the
    // truncated result and everything from the result sign bit up must agree.
    function automatic logic signed [PW-1:0] mul_shifted(
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] y
    );
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ye;
        logic signed [PW-1:0] prod;
        xe   = $signed({{WIDTH{x[WIDTH-1]}}, x});
        ye   = $signed({{WIDTH{y[WIDTH-1]}}, y});
        prod = xe * ye;
        return prod >>> FRAC;
    endfunction

    function automatic logic mul_ovf(input logic signed [PW-1:0] sh);
        return !((&sh[PW-1:WIDTH-1]) || !(|sh[PW-1:WIDTH-1]));
    endfunction

    logic signed [WIDTH-1:0] sum;
    logic signed [WIDTH-1:0] diff;
    logic signed [PW-1:0]    mul_sh;

    assign sum    = a + b;
    assign diff   = a - b;
    assign mul_sh = mul_shifted(a, b);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        write_en = 1'b0;
        case (op)
            COPY: begin
                result   = a;
                write_en = 1'b1;
            end
            LOADONE: begin
                result   = zext16(sample_data);
                write_en = 1'b1;
            end
            LOADTWO: begin
                result   = zext16(fir_coefficient);
                write_en = 1'b1;
            end
            ADD: begin
                result   = sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                write_en = 1'b1;
            end
            SUB: begin
                result   = diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                write_en = 1'b1;
            end
            MUL: begin
                result   = mul_sh[WIDTH-1:0];
                overflow = mul_ovf(mul_sh);
                write_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fir_datapath.sv
// FIR execution datapath: 16-entry register file read combinationally,
// written at the clock edge, with R0 mirrored into a dedicated output flop.
module fir_datapath
    import fir_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int WIDTH = fir_pkg::WIDTH,
    parameter int FRAC  = fir_pkg::FRAC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        op,
    input  logic [3:0]        src1,
    input  logic [3:0]        src2,
    input  logic [3:0]        dest,
    input  logic [15:0]       sample_data,
    input  logic [15:0]       fir_coefficient,
    output logic              overflow,
    output logic [WIDTH-1:0]  outreg_data
);

    logic signed [WIDTH-1:0] regs [NREGS];
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic signed [WIDTH-1:0] result;
    logic                    write_en;
    opType                   op_e;

    assign op_e = opType'(op);
    assign a    = regs[src1];
    assign b    = regs[src2];

    fir_alu #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_alu (
        .op              (op_e),
        .a               (a),
        .b               (b),
        .sample_data     (sample_data),
        .fir_coefficient (fir_coefficient),
        .result          (result),
        .overflow        (overflow),
        .write_en        (write_en)
    );

    // Write-back edge: register file and the R0 output mirror update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            outreg_data <= '0;
        end else if (write_en) begin
            regs[dest] <= result;
            if (dest == R_ACC) outreg_data <= result;
        end
    end

endmodule

// File: tb/tb_fir_datapath.sv
// Directed bench for fir_datapath: a table of micro-ops with hand-computed
// overflow, register and output values, then reset-during-write corner cases.
module tb_fir_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  op;
    logic [3:0]  src1, src2, dest;
    logic [15:0] sample_data, fir_coefficient;
    logic        overflow;
    logic [16:0] outreg_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    fir_datapath dut (
        .clk             (clk),
        .reset           (reset),
        .op              (op),
        .src1            (src1),
        .src2            (src2),
        .dest            (dest),
        .sample_data     (sample_data),
        .fir_coefficient (fir_coefficient),
        .overflow        (overflow),
        .outreg_data     (outreg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [3:0]  d;
        logic [15:0] smp;
        logic [15:0] coef;
        logic        exp_ovf;
        logic [3:0]  ridx;
        logic [16:0] exp_reg;
        logic [16:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add_vec(input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2,
                           input logic [3:0] d, input logic [15:0] smp, input logic [15:0] coef,
                           input logic eo, input logic [3:0] ri, input logic [16:0] er,
                           input logic [16:0] eout);
        vec_t v;
        v.op = o; v.s1 = s1; v.s2 = s2; v.d = d; v.smp = smp; v.coef = coef;
        v.exp_ovf = eo; v.ridx = ri; v.exp_reg = er; v.exp_out = eout;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] d, input logic [15:0] smp, input logic [15:0] coef);
        op = o; src1 = s1; src2 = s2; dest = d; sample_data = smp; fir_coefficient = coef;
    endtask

    initial begin
        // op: 0 NOP 1 COPY 2 LOADONE 3 LOADTWO 4 ADD 5 SUB 6 MUL 7 reserved
        add_vec(3'd2, 4'd0, 4'd0, 4'd5,  16'd100,   16'h0,    1'b0, 4'd5,  17'd100,    17'h0);
        add_vec(3'd2, 4'd0, 4'd0, 4'd1,  16'hFFFF,  16'h0,    1'b0, 4'd1,  17'h0FFFF,  17'h0);
        add_vec(3'd2, 4'd0, 4'd0, 4'd2,  16'd1,     16'h0,    1'b0, 4'd2,  17'd1,      17'h0);
        add_vec(3'd4, 4'd1, 4'd2, 4'd0,  16'h0,     16'h0,    1'b1, 4'd0,  17'h10000,  17'h10000);
        add_vec(3'd5, 4'd0, 4'd2, 4'd11, 16'h0,     16'h0,    1'b1, 4'd11, 17'h0FFFF,  17'h10000);
        add_vec(3'd2, 4'd0, 4'd0, 4'd1,  16'd1000,  16'h0,    1'b0, 4'd1,  17'd1000,   17'h10000);
        add_vec(3'd3, 4'd0, 4'd0, 4'd6,  16'h0,     16'h4000, 1'b0, 4'd6,  17'h04000,  17'h10000);
        add_vec(3'd6, 4'd1, 4'd6, 4'd10, 16'h0,     16'h0,    1'b0, 4'd10, 17'd500,    17'h10000);
        add_vec(3'd5, 4'd0, 4'd0, 4'd0,  16'h0,     16'h0,    1'b0, 4'd0,  17'h0,      17'h0);
        add_vec(3'd5, 4'd0, 4'd10, 4'd0, 16'h0,     16'h0,    1'b0, 4'd0,  17'h1FE0C,  17'h1FE0C);
        add_vec(3'd2, 4'd0, 4'd0, 4'd3,  16'hFFFF,  16'h0,    1'b0, 4'd3,  17'h0FFFF,  17'h1FE0C);
        add_vec(3'd3, 4'd0, 4'd0, 4'd8,  16'h0,     16'hFFFF, 1'b0, 4'd8,  17'h0FFFF,  17'h1FE0C);
        add_vec(3'd6, 4'd3, 4'd8, 4'd10, 16'h0,     16'h0,    1'b1, 4'd10, 17'h1FFFC,  17'h1FE0C);
        add_vec(3'd2, 4'd0, 4'd0, 4'd2,  16'h0ABC,  16'h0,    1'b0, 4'd2,  17'h00ABC,  17'h1FE0C);
        add_vec(3'd1, 4'd2, 4'd0, 4'd1,  16'h0,     16'h0,    1'b0, 4'd1,  17'h00ABC,  17'h1FE0C);
        add_vec(3'd1, 4'd1, 4'd0, 4'd3,  16'h0,     16'h0,    1'b0, 4'd3,  17'h00ABC,  17'h1FE0C);
        add_vec(3'd2, 4'd0, 4'd0, 4'd0,  16'd7,     16'h0,    1'b0, 4'd0,  17'd7,      17'd7);
        add_vec(3'd4, 4'd0, 4'd0, 4'd0,  16'h0,     16'h0,    1'b0, 4'd0,  17'd14,     17'd14);
        add_vec(3'd0, 4'd1, 4'd2, 4'd0,  16'h1111,  16'h2222, 1'b0, 4'd0,  17'd14,     17'd14);
        add_vec(3'd2, 4'd0, 4'd0, 4'd4,  16'h0055,  16'h0,    1'b0, 4'd4,  17'h00055,  17'd14);
        add_vec(3'd7, 4'd1, 4'd2, 4'd4,  16'h1234,  16'h5678, 1'b0, 4'd4,  17'h00055,  17'd14);

        reset = 1'b1;
        drive(3'd0, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outreg", outreg_data, 17'h0);
        chk("reset_r5", dut.regs[5], 17'h0);
        chk("reset_ovf", {16'h0, overflow}, 17'h0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].d, vecs[i].smp, vecs[i].coef);
            @(negedge clk);
            chk($sformatf("v%0d_ovf", i), {16'h0, overflow}, {16'h0, vecs[i].exp_ovf});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_reg", i), dut.regs[vecs[i].ridx], vecs[i].exp_reg);
            chk($sformatf("v%0d_out", i), outreg_data, vecs[i].exp_out);
        end

        // Reset asserted while an ADD to R4 is in flight: write discarded.
        drive(3'd4, 4'd0, 4'd0, 4'd4, 16'h0, 16'h0);
        @(negedge clk);
        chk("pre_rst_ovf", {16'h0, overflow}, 17'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_r4", dut.regs[4], 17'h0);
        chk("rst_mid_r0", dut.regs[0], 17'h0);
        chk("rst_mid_out", outreg_data, 17'h0);
        reset = 1'b0;

        // Load R0 then write same-cycle src==dest: old value read, new stored.
        drive(3'd2, 4'd0, 4'd0, 4'd0, 16'h4000, 16'h0);
        @(posedge clk);
        #1;
        drive(3'd4, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
        @(negedge clk);
        chk("dbl_ovf", {16'h0, overflow}, 17'h0);
        @(posedge clk);
        #1;
        chk("dbl_out", outreg_data, 17'h08000);
        drive(3'd4, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0);
        @(negedge clk);
        chk("dbl2_ovf", {16'h0, overflow}, 17'h1);
        @(posedge clk);
        #1;
        chk("dbl2_out", outreg_data, 17'h10000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fir_datapath.md
# fir_datapath

Single-cycle execution datapath for the FIR filter core. Sits directly downstream of the FIR sequencing controller: each cycle it executes the `op`/`src1`/`src2`/`dest` micro-instruction the controller drives, writes the result into a 16-entry register file, and returns a combinational `overflow` flag the controller samples in the same cycle to branch to its error state. Register R0 is the accumulator and drives the filter output.

## Interface
- `NREGS`, 16: register file depth; addresses are 4 bits.
- `WIDTH`, 17: register width, two's-complement signed.
- `FRAC`, 15: fractional bits of coefficients; MUL right-shift amount.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- `op`  in  3  micro-op: 0 NOP, 1 COPY, 2 LOADONE, 3 LOADTWO, 4 ADD, 5 SUB, 6 MUL, 7 reserved.
- `src1`  in  4  first operand register address.
- `src2`  in  4  second operand register address.
- `dest`  in  4  destination register address.
- `sample_data`  in  16  unsigned sample, zero-extended to 17 bits by LOADONE.
- `fir_coefficient`  in  16  unsigned Q1.15 coefficient, zero-extended by LOADTWO.
- `overflow`  out  1  combinational; signed overflow of the op presented this cycle.
- `outreg_data`  out  17  registered copy of R0.

## Operation
- A = R[src1], B = R[src2], read from the pre-edge register contents.
- NOP: no write. COPY: R[dest] <= A. LOADONE: R[dest] <= {1'b0, sample_data}. LOADTWO: R[dest] <= {1'b0, fir_coefficient}.
- ADD: R[dest] <= (A + B) mod 2^17; overflow = sign(A)==sign(B) and sign(result)!=sign(A).
- SUB: R[dest] <= (A − B) mod 2^17; overflow = sign(A)!=sign(B) and sign(result)!=sign(A).
- MUL: P = signed(A) × signed(B), 34 bits; R[dest] <= P[31:15]; overflow = 1 when P[33], P[32], P[31] are not all equal.
- Result is written even when overflow=1, so the wrapped/truncated value is stored.
- op 7: treated as NOP, overflow=0, no write.
- NOP, COPY, LOADONE, LOADTWO: overflow=0.
- R0 has no special hardware; the controller clears it with SUB R0−R0.
- `outreg_data` is the value of R0 after the most recent edge. It is a distinct flop that loads the R0 write data whenever dest==0 and a write occurs.

## Timing
- Reset: all R[i] = 0, `outreg_data` = 0. `overflow` is combinational and follows the current inputs during reset. Asserting reset mid-operation discards the write for that cycle.
- Latency: an op presented in cycle n is written at the rising edge ending cycle n. A consumer op in cycle n+1 sees the new value. No bypass is needed and none is implemented.
- `overflow` settles within cycle n from `op`, src registers, and operands, with no register stage. The controller's next-state logic consumes it before the same edge.
- src==dest, including src1==src2==dest: reads return the old value and the write lands at the edge.
- There is no handshake or stall, and every cycle is an instruction. `sample_data`/`fir_coefficient` are sampled only on the LOADONE/LOADTWO edge.

## Structure
- Shared package `fir_pkg`: `opType` enum (NOP…MUL, 3 bits, values above), `WIDTH`/`FRAC` constants, and register index constants (R_ACC=0, R_TMP=10, sample slots 1–5, coefficient slots 6–9). The controller imports the same enum.
- Sub-module `fir_alu`: purely combinational `op`, A, B → result, overflow, write_en.
- `fir_datapath` holds the register file, the output flop, and the `fir_alu` instance.

## Test plan
- Reset then LOADONE dest=5 with sample_data=100 → next cycle R5=100, outreg_data=0, overflow=0 throughout.
- Load R1=65535 and R2=1, then ADD src1=1 src2=2 dest=0 → overflow=1 in that cycle, R0=outreg_data=0x10000 after the edge.
- Load R1=1000 and R6 (LOADTWO)=0x4000, then MUL 1,6 → 10 → R10=500, overflow=0. Then SUB 0,10 → 0 starting from R0=0 → R0=0x1FE0C (−500), overflow=0.
- Load R3=0xFFFF and R8=0xFFFF, then MUL 3,8 → 10 → overflow=1 and R10=P[31:15] of 65535².
- Back-to-back: COPY 2→1 followed by COPY 1→3 → R3 equals the original R2. ADD 0,0→0 with R0=7 → R0=14.
- Assert reset during an ADD to dest 4 → R4=0 and outreg_data=0. op=7 with dest=4 → no change, overflow=0.
